// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - multi-channel arbiter for a single shared SRAM port
//
// Purpose: grants one of NUM_CH requesters at a time access to a single
// synchronous SRAM port, runs one transaction (read or byte-masked write)
// to completion, returns read data into a per-channel register and pulses
// a per-channel done strobe.
//
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration starting after the last grant
//   undefined -> fixed priority, lowest channel index wins
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_en     in   [NUM_CH]          per-channel request valid
//   req_wen    in   [NUM_CH*BE_W]     per-channel byte write enables (0 = read)
//   req_addr   in   [NUM_CH*ADDR_W]   per-channel address
//   req_wdata  in   [NUM_CH*DATA_W]   per-channel write data
//   req_rdata  out  [NUM_CH*DATA_W]   per-channel registered read data
//   req_stall  out  [NUM_CH]          request pending and not yet done
//   req_done   out  [NUM_CH]          one-cycle completion pulse
//   mem_en     out                    SRAM access strobe (ISSUE cycle only)
//   mem_wen    out  [BE_W]            SRAM byte write enables
//   mem_addr   out  [ADDR_W]          SRAM address
//   mem_wdata  out  [DATA_W]          SRAM write data
//   mem_rdata  in   [DATA_W]          SRAM read data, valid MEM_LAT cycles after issue

module sram_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_en,
    input  logic [NUM_CH*(DATA_W/8)-1:0] req_wen,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH*DATA_W-1:0] req_rdata,
    output logic [NUM_CH-1:0]        req_stall,
    output logic [NUM_CH-1:0]        req_done,
    output logic                     mem_en,
    output logic [DATA_W/8-1:0]      mem_wen,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic [BE_W-1:0]            wen_q;
    logic [NUM_CH*DATA_W-1:0]   rdata_q;
    logic [NUM_CH-1:0]          done_q;
    logic                       mem_en_q;
    logic [BE_W-1:0]            mem_wen_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [DATA_W-1:0]          mem_wdata_q;

    logic                       grant_vld_d;
    logic [IDX_W-1:0]           grant_idx_d;
    logic [IDX_W-1:0]           cand_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Index of the most recently granted channel; search begins one past it.
    logic [IDX_W-1:0]           ptr_q;

    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        cand_d      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_d = IDX_W'((int'(ptr_q) + k) % NUM_CH);
            if (!grant_vld_d && req_en[cand_d]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = cand_d;
            end
        end
    end
`else
    // Walk from the highest index down so the lowest requesting index wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        cand_d      = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            cand_d = IDX_W'(c);
            if (req_en[cand_d]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = cand_d;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wen_q       <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr_q       <= IDX_W'(NUM_CH - 1);
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        // The memory port registers double as the latched
                        // address/data; mem_en goes high for the ISSUE cycle.
                        idx_q       <= grant_idx_d;
                        wen_q       <= req_wen[grant_idx_d*BE_W +: BE_W];
                        mem_en_q    <= 1'b1;
                        mem_wen_q   <= req_wen[grant_idx_d*BE_W +: BE_W];
                        mem_addr_q  <= req_addr[grant_idx_d*ADDR_W +: ADDR_W];
                        mem_wdata_q <= req_wdata[grant_idx_d*DATA_W +: DATA_W];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        ptr_q       <= grant_idx_d;
`endif
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_en_q  <= 1'b0;
                    mem_wen_q <= '0;
                    cnt_q     <= CNT_W'(MEM_LAT);
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter reaches 1 in cycle T+MEM_LAT, when mem_rdata is valid.
                    if (cnt_q == CNT_W'(1)) begin
                        if (wen_q == '0) begin
                            rdata_q[idx_q*DATA_W +: DATA_W] <= mem_rdata;
                        end
                        done_q[idx_q] <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_rdata = rdata_q;
    assign req_done  = done_q;
    assign req_stall = req_en & ~done_q;
    assign mem_en    = mem_en_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // Default configuration: NUM_CH=2, DATA_W=32, MEM_LAT=1
    logic [1:0]   req_en    = '0;
    logic [7:0]   req_wen   = '0;
    logic [63:0]  req_addr  = '0;
    logic [63:0]  req_wdata = '0;
    logic [63:0]  req_rdata;
    logic [1:0]   req_stall;
    logic [1:0]   req_done;
    logic         mem_en;
    logic [3:0]   mem_wen;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;

    // Wide configuration: NUM_CH=4, DATA_W=64, MEM_LAT=3
    logic [3:0]   req_en4    = '0;
    logic [31:0]  req_wen4   = '0;
    logic [127:0] req_addr4  = '0;
    logic [255:0] req_wdata4 = '0;
    logic [255:0] req_rdata4;
    logic [3:0]   req_stall4;
    logic [3:0]   req_done4;
    logic         mem_en4;
    logic [7:0]   mem_wen4;
    logic [31:0]  mem_addr4;
    logic [63:0]  mem_wdata4;
    logic [63:0]  mem_rdata4 = '0;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .req_stall(req_stall), .req_done(req_done),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    sram_port_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(64), .MEM_LAT(3)) dut4 (
        .clk(clk), .rst(rst),
        .req_en(req_en4), .req_wen(req_wen4), .req_addr(req_addr4), .req_wdata(req_wdata4),
        .req_rdata(req_rdata4), .req_stall(req_stall4), .req_done(req_done4),
        .mem_en(mem_en4), .mem_wen(mem_wen4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %0b want 0", mem_en); end
        checks++; if (mem_wen !== 4'h0) begin errors++; $display("FAIL rst_mem_wen: got %h want 0", mem_wen); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if (req_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", req_rdata); end
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL rst_done: got %b want 00", req_done); end
        checks++; if (req_stall !== 2'b00) begin errors++; $display("FAIL rst_stall: got %b want 00", req_stall); end
        checks++; if (req_rdata4 !== 256'h0) begin errors++; $display("FAIL rst_rdata4: got %h want 0", req_rdata4); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        // Cycle T-1: request presented while IDLE
        req_en = 2'b01; req_wen = 8'h00; req_addr[31:0] = 32'h1FC0_0000;
        #1;
        checks++; if (req_stall !== 2'b01) begin errors++; $display("FAIL rd_stall_tm1: got %b want 01", req_stall); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rd_en_tm1: got %0b want 0", mem_en); end
        tick(); // T: ISSUE
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rd_en_t: got %0b want 1", mem_en); end
        checks++; if (mem_addr !== 32'h1FC0_0000) begin errors++; $display("FAIL rd_addr_t: got %h want 1fc00000", mem_addr); end
        checks++; if (mem_wen !== 4'h0) begin errors++; $display("FAIL rd_wen_t: got %h want 0", mem_wen); end
        checks++; if (req_stall !== 2'b01) begin errors++; $display("FAIL rd_stall_t: got %b want 01", req_stall); end
        mem_rdata = 32'h2408_0001;
        tick(); // T+1: WAIT
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rd_en_t1: got %0b want 0", mem_en); end
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL rd_done_t1: got %b want 00", req_done); end
        checks++; if (req_stall !== 2'b01) begin errors++; $display("FAIL rd_stall_t1: got %b want 01", req_stall); end
        tick(); // T+2: DONE
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rd_done_t2: got %b want 01", req_done); end
        checks++; if (req_stall !== 2'b00) begin errors++; $display("FAIL rd_stall_t2: got %b want 00", req_stall); end
        checks++; if (req_rdata[31:0] !== 32'h2408_0001) begin errors++; $display("FAIL rd_data: got %h want 24080001", req_rdata[31:0]); end
        req_en = 2'b00;
        tick(); // IDLE
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL rd_done_after: got %b want 00", req_done); end
        checks++; if (mem_addr !== 32'h1FC0_0000) begin errors++; $display("FAIL rd_addr_hold: got %h want 1fc00000", mem_addr); end
    endtask

    task automatic test_write();
        req_en = 2'b10; req_wen = {4'b0011, 4'b0000};
        req_addr[63:32] = 32'h0000_0010; req_wdata[63:32] = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        tick(); // ISSUE
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL wr_en: got %0b want 1", mem_en); end
        checks++; if (mem_wen !== 4'b0011) begin errors++; $display("FAIL wr_wen: got %b want 0011", mem_wen); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
        checks++; if (mem_addr !== 32'h0000_0010) begin errors++; $display("FAIL wr_addr: got %h want 00000010", mem_addr); end
        tick(); // WAIT
        checks++; if (mem_wen !== 4'b0000) begin errors++; $display("FAIL wr_wen_wait: got %b want 0000", mem_wen); end
        tick(); // DONE
        checks++; if (req_done !== 2'b10) begin errors++; $display("FAIL wr_done: got %b want 10", req_done); end
        checks++; if (req_rdata !== {32'h0, 32'h2408_0001}) begin errors++; $display("FAIL wr_rdata: got %h want 0000000024080001", req_rdata); end
        req_en = 2'b00; req_wen = 8'h00;
        tick();
    endtask

    task automatic test_arbitration();
        int exp;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_wen = 8'h00;
        mem_rdata = 32'hA0A0_A0A0;
        req_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp = i % 2;
`else
            exp = 0;
`endif
            tick(); // ISSUE
            checks++; if (mem_en !== 1'b1 || mem_addr !== (exp == 1 ? 32'h200 : 32'h100)) begin
                errors++; $display("FAIL arb_grant%0d: got en=%0b addr=%h want ch%0d", i, mem_en, mem_addr, exp);
            end
            tick(); // WAIT
            tick(); // DONE
            checks++; if (req_done !== 2'(1 << exp)) begin errors++; $display("FAIL arb_done%0d: got %b want ch%0d", i, req_done, exp); end
            checks++; if (req_stall[1] !== (exp != 1)) begin errors++; $display("FAIL arb_stall1_%0d: got %0b want %0b", i, req_stall[1], exp != 1); end
            if (i == 3) req_en = 2'b00;
            tick(); // IDLE
        end
        tick();
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL arb_quiet: got %0b want 0", mem_en); end
    endtask

    task automatic test_long_latency();
        req_en4 = 4'b0100; req_wen4 = '0; req_addr4[95:64] = 32'h0000_0040;
        mem_rdata4 = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); // T: ISSUE
        checks++; if (mem_en4 !== 1'b1 || mem_addr4 !== 32'h40) begin errors++; $display("FAIL lat_issue: got en=%0b addr=%h want 1/40", mem_en4, mem_addr4); end
        tick(); // T+1
        checks++; if (mem_en4 !== 1'b0) begin errors++; $display("FAIL lat_en_t1: got %0b want 0", mem_en4); end
        tick(); // T+2
        checks++; if (req_done4 !== 4'b0000) begin errors++; $display("FAIL lat_done_t2: got %b want 0000", req_done4); end
        tick(); // T+3: data valid this cycle only
        mem_rdata4 = 64'h0123_4567_89AB_CDEF;
        checks++; if (req_done4 !== 4'b0000) begin errors++; $display("FAIL lat_done_t3: got %b want 0000", req_done4); end
        tick(); // T+4: DONE
        mem_rdata4 = 64'hCAFE_F00D_1234_5678;
        checks++; if (req_done4 !== 4'b0100) begin errors++; $display("FAIL lat_done_t4: got %b want 0100", req_done4); end
        checks++; if (req_rdata4 !== {64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0}) begin
            errors++; $display("FAIL lat_slot: got %h want slot2=0123456789abcdef only", req_rdata4);
        end
        tick(); // T+5: IDLE, request still held
        checks++; if (mem_en4 !== 1'b0 || req_done4 !== 4'b0000) begin errors++; $display("FAIL lat_t5: got en=%0b done=%b want 0/0000", mem_en4, req_done4); end
        tick(); // T+6: next ISSUE
        checks++; if (mem_en4 !== 1'b1) begin errors++; $display("FAIL lat_reissue_t6: got %0b want 1", mem_en4); end
        req_en4 = 4'b0000; // dropped mid-transaction, must still complete
        tick(); tick(); tick(); // T+7..T+9 WAIT
        checks++; if (req_done4 !== 4'b0000) begin errors++; $display("FAIL lat_done_t9: got %b want 0000", req_done4); end
        tick(); // T+10 DONE
        checks++; if (req_done4 !== 4'b0100) begin errors++; $display("FAIL lat_drop_done: got %b want 0100", req_done4); end
        checks++; if (req_rdata4[191:128] !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL lat_drop_data: got %h want cafef00d12345678", req_rdata4[191:128]); end
        checks++; if (req_stall4 !== 4'b0000) begin errors++; $display("FAIL lat_drop_stall: got %b want 0000", req_stall4); end
        tick();
    endtask

    task automatic test_reset_mid();
        req_en = 2'b01; req_wen = 8'h00; req_addr[31:0] = 32'h0000_0020;
        mem_rdata = 32'h1111_2222;
        tick(); // ISSUE
        tick(); // WAIT
        rst = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_wen !== 4'h0) begin errors++; $display("FAIL rstm_en: got en=%0b wen=%h want 0/0", mem_en, mem_wen); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rstm_port: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (req_rdata !== 64'h0) begin errors++; $display("FAIL rstm_rdata: got %h want 0", req_rdata); end
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL rstm_done: got %b want 00", req_done); end
        tick();
        checks++; if (req_done !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL rstm_held: got done=%b en=%0b want 00/0", req_done, mem_en); end
        @(negedge clk);
        rst = 1'b0;
        tick(); // first edge after release: IDLE accepts, now ISSUE
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL rstm_reissue: got en=%0b addr=%h want 1/20", mem_en, mem_addr); end
        tick(); // WAIT
        tick(); // DONE
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rstm_done2: got %b want 01", req_done); end
        checks++; if (req_rdata[31:0] !== 32'h1111_2222) begin errors++; $display("FAIL rstm_data: got %h want 11112222", req_rdata[31:0]); end
        req_en = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_arbitration();
        test_long_latency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
